// File: rtl/ao68000_micro_pkg.sv
// Shared definitions for the microcode sequencer: widths, op codes and
// microword field positions, plus a helper that slices a microword.
package ao68000_micro_pkg;

  localparam int MPC_W   = 9;
  localparam int MWORD_W = 88;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_BRANCH   = 3'd2;
  localparam logic [2:0] SEQ_CALL     = 3'd3;
  localparam logic [2:0] SEQ_RETURN   = 3'd4;
  localparam logic [2:0] SEQ_DISPATCH = 3'd5;
  localparam logic [2:0] SEQ_WAIT     = 3'd6;

  localparam int SEQ_OP_HI    = 87;
  localparam int SEQ_OP_LO    = 85;
  localparam int COND_NEG_BIT = 84;
  localparam int COND_SEL_HI  = 83;
  localparam int COND_SEL_LO  = 80;
  localparam int TARGET_HI    = 79;
  localparam int TARGET_LO    = 71;

  typedef struct packed {
    logic [2:0]       op;
    logic             cond_neg;
    logic [3:0]       cond_sel;
    logic [MPC_W-1:0] target;
  } mfields_t;

  function automatic mfields_t unpack_fields(input logic [MWORD_W-1:0] word);
    mfields_t f;
    f.op       = word[SEQ_OP_HI:SEQ_OP_LO];
    f.cond_neg = word[COND_NEG_BIT];
    f.cond_sel = word[COND_SEL_HI:COND_SEL_LO];
    f.target   = word[TARGET_HI:TARGET_LO];
    return f;
  endfunction

endpackage

// File: rtl/microcode_return_stack.sv
// Return-address LIFO for microcode CALL/RETURN. Pushes when full and pops
// when empty are ignored here; the sequencer flags them as stack errors.
module microcode_return_stack
  import ao68000_micro_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [MPC_W-1:0] din,
  output logic [MPC_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [MPC_W-1:0] mem [STACK_DEPTH];
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(STACK_DEPTH));
  assign empty = (count == '0);

  // Top of stack; content is meaningless while empty.
  assign dout = mem[IDX_W'(count - CNT_W'(1))];

  // Occupancy counter; flush empties the stack without touching storage.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage, written at the current fill level.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push && !full) begin
      mem[IDX_W'(count)] <= din;
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Next-address generator for the registered-address microcode ROM.
// micro_pc is combinational and feeds the ROM address; the word for
// current_pc arrives on micro_data in the following cycle.
module microcode_sequencer
  import ao68000_micro_pkg::*;
#(
  parameter logic [MPC_W-1:0] RESET_ADDR  = 9'd0,
  parameter int               STACK_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  output logic [MPC_W-1:0]   micro_pc,
  input  logic [MWORD_W-1:0] micro_data,
  output logic [MPC_W-1:0]   current_pc,
  output logic               micro_valid,
  input  logic               stall,
  input  logic [15:0]        cond_flags,
  input  logic [MPC_W-1:0]   decode_address,
  input  logic               decode_valid,
  input  logic               exception_req,
  input  logic [MPC_W-1:0]   exception_address,
  output logic               exception_ack,
  output logic               stack_error
);

  mfields_t         fields;
  logic [15:0]      flags;
  logic             cond;
  logic [MPC_W-1:0] pc_inc;
  logic [MPC_W-1:0] stack_top;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_push;
  logic             stack_pop;
  logic             stack_fault;
  logic             exc_pending;

  assign fields = unpack_fields(micro_data);
  // Condition 0 is hard-wired true so cond_sel=0 gives unconditional forms.
  assign flags  = {cond_flags[15:1], 1'b1};
  assign cond   = flags[fields.cond_sel] ^ fields.cond_neg;
  assign pc_inc = current_pc + MPC_W'(1);

  // Next-address selection: reset, stall, exception entry, then op decode.
  always_comb begin
    micro_pc      = current_pc;
    micro_valid   = 1'b0;
    exception_ack = 1'b0;
    stack_push    = 1'b0;
    stack_pop     = 1'b0;
    stack_fault   = 1'b0;
    if (reset) begin
      micro_pc = RESET_ADDR;
    end else if (stall) begin
      micro_pc = current_pc;
    end else if (exc_pending) begin
      // The word on micro_data is abandoned in favour of the handler.
      micro_pc      = exception_address;
      exception_ack = 1'b1;
    end else begin
      micro_valid = 1'b1;
      case (fields.op)
        SEQ_JUMP:   micro_pc = fields.target;
        SEQ_BRANCH: micro_pc = cond ? fields.target : pc_inc;
        SEQ_CALL: begin
          micro_pc = fields.target;
          if (stack_full) begin
            stack_fault = 1'b1;
          end else begin
            stack_push = 1'b1;
          end
        end
        SEQ_RETURN: begin
          if (stack_empty) begin
            stack_fault = 1'b1;
            micro_pc    = RESET_ADDR;
          end else begin
            stack_pop = 1'b1;
            micro_pc  = stack_top;
          end
        end
        SEQ_DISPATCH: begin
          if (decode_valid) begin
            micro_pc = decode_address;
          end else begin
            micro_pc    = current_pc;
            micro_valid = 1'b0;
          end
        end
        SEQ_WAIT:   micro_pc = cond ? pc_inc : current_pc;
        default:    micro_pc = pc_inc;
      endcase
    end
  end

  // Address register plus exception-pending and sticky stack-error flags.
  always_ff @(posedge clock) begin
    current_pc <= micro_pc;
    if (reset) begin
      exc_pending <= 1'b0;
      stack_error <= 1'b0;
    end else begin
      // Entry consumes the request; it must be dropped by the ack cycle.
      if (exception_ack) begin
        exc_pending <= 1'b0;
      end else if (exception_req) begin
        exc_pending <= 1'b1;
      end
      if (stack_fault) begin
        stack_error <= 1'b1;
      end
    end
  end

  microcode_return_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clock(clock),
    .reset(reset),
    .push (stack_push),
    .pop  (stack_pop),
    .flush(exception_ack),
    .din  (pc_inc),
    .dout (stack_top),
    .full (stack_full),
    .empty(stack_empty)
  );

endmodule
